// File: rtl/stack_warning_pkg.sv
// Shared types and default constants for the multi-channel drowsiness accumulator.
package stack_warning_pkg;

    typedef enum logic [0:0] {
        MODE_RESET = 1'b0,
        MODE_LEAKY = 1'b1
    } mode_e;

    localparam int SLEEPTIME_DEF = 240;
    localparam int GROUP_DEF     = 2;
    localparam int CNT_W_DEF     = 11;

endpackage

// File: rtl/stack_warning_ch.sv
// One accumulator channel: windows samples, counts consecutive asleep windows
// and drives a hysteretic warning from the updated count.
module stack_warning_ch
    import stack_warning_pkg::*;
#(
    parameter int GROUP     = GROUP_DEF,
    parameter int SLEEPTIME = SLEEPTIME_DEF,
    parameter int HYST      = 0,
    parameter int MODE      = 0,
    parameter int DECAY     = 1,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             data_i,
    input  logic             clr_i,
    output logic             warning_o,
    output logic             group_done_o,
    output logic [CNT_W-1:0] stack_o
);

    localparam int K_W       = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int MAX_INT   = (1 << CNT_W) - 1;
    localparam int DECAY_CL  = (DECAY > MAX_INT) ? MAX_INT : DECAY;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(GROUP - 1);
    localparam logic [K_W-1:0]   K_ONE    = K_W'(1);
    localparam logic [CNT_W:0]   CNT_MAX  = (CNT_W + 1)'(MAX_INT);
    localparam logic [CNT_W:0]   CNT_ONE  = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   DECAY_W  = (CNT_W + 1)'(DECAY_CL);
    localparam logic [CNT_W:0]   SLEEP_TH = (CNT_W + 1)'(SLEEPTIME);
    localparam logic [CNT_W:0]   CLEAR_TH = (CNT_W + 1)'(SLEEPTIME - HYST);

    logic [K_W-1:0]   k_q;
    logic             awake_q;
    logic [CNT_W-1:0] stack_q;
    logic             warning_q;
    logic             group_done_q;

    logic             window_awake_s;
    logic [CNT_W:0]   stack_ext_s;
    logic [CNT_W:0]   stack_inc_s;
    logic [CNT_W:0]   stack_calc_s;
    logic [CNT_W-1:0] stack_d;
    logic             warning_d;

    // Next count and warning for the window closed by the current sample.
    always_comb begin
        window_awake_s = awake_q | data_i;
        stack_ext_s    = {1'b0, stack_q};
        stack_inc_s    = stack_ext_s + CNT_ONE;
        stack_calc_s   = stack_ext_s;
        if (!window_awake_s) begin
            stack_calc_s = (stack_inc_s > CNT_MAX) ? CNT_MAX : stack_inc_s;
        end else if (MODE == int'(MODE_LEAKY)) begin
            stack_calc_s = (stack_ext_s > DECAY_W) ? (stack_ext_s - DECAY_W) : '0;
        end else begin
            stack_calc_s = '0;
        end
        stack_d = stack_calc_s[CNT_W-1:0];

        if (stack_calc_s >= SLEEP_TH) begin
            warning_d = 1'b1;
        end else if (stack_calc_s < CLEAR_TH) begin
            warning_d = 1'b0;
        end else begin
            warning_d = warning_q;
        end
    end

    // Channel state; a flush beats a same-cycle sample.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            k_q          <= '0;
            awake_q      <= 1'b0;
            stack_q      <= '0;
            warning_q    <= 1'b0;
            group_done_q <= 1'b0;
        end else begin
            group_done_q <= 1'b0;
            if (valid_i) begin
                if (k_q == K_LAST) begin
                    k_q          <= '0;
                    awake_q      <= 1'b0;
                    stack_q      <= stack_d;
                    warning_q    <= warning_d;
                    group_done_q <= 1'b1;
                end else begin
                    k_q     <= k_q + K_ONE;
                    awake_q <= awake_q | data_i;
                end
            end else begin
                k_q <= k_q;
            end
        end
    end

    assign warning_o    = warning_q;
    assign group_done_o = group_done_q;
    assign stack_o      = stack_q;

endmodule

// File: rtl/stack_warning_mc.sv
// Multi-channel drowsiness accumulator: CH independent channels, packed counts
// and a combined alarm for the alert driver.
module stack_warning_mc
    import stack_warning_pkg::*;
#(
    parameter int CH        = 2,
    parameter int GROUP     = GROUP_DEF,
    parameter int SLEEPTIME = SLEEPTIME_DEF,
    parameter int HYST      = 0,
    parameter int MODE      = 0,
    parameter int DECAY     = 1,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       valid_in,
    input  logic [CH-1:0]       data_in,
    input  logic [CH-1:0]       clr_in,
    output logic [CH-1:0]       warning,
    output logic                warning_any,
    output logic [CH*CNT_W-1:0] stack_out,
    output logic [CH-1:0]       group_done
);

    if (CH < 1) begin : g_bad_ch
        $error("CH must be at least 1");
    end
    if (GROUP < 1) begin : g_bad_group
        $error("GROUP must be at least 1");
    end
    if ((SLEEPTIME < 1) || (SLEEPTIME > (1 << CNT_W) - 1)) begin : g_bad_sleep
        $error("SLEEPTIME must lie in 1 .. 2^CNT_W-1");
    end
    if ((HYST < 0) || (HYST >= SLEEPTIME)) begin : g_bad_hyst
        $error("HYST must lie in 0 .. SLEEPTIME-1");
    end
    if ((MODE != 0) && (MODE != 1)) begin : g_bad_mode
        $error("MODE must be 0 or 1");
    end
    if (DECAY < 1) begin : g_bad_decay
        $error("DECAY must be at least 1");
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        stack_warning_ch #(
            .GROUP     (GROUP),
            .SLEEPTIME (SLEEPTIME),
            .HYST      (HYST),
            .MODE      (MODE),
            .DECAY     (DECAY),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .valid_i      (valid_in[c]),
            .data_i       (data_in[c]),
            .clr_i        (clr_in[c]),
            .warning_o    (warning[c]),
            .group_done_o (group_done[c]),
            .stack_o      (stack_out[c*CNT_W +: CNT_W])
        );
    end

    assign warning_any = |warning;

endmodule

// File: tb/tb_stack_warning_mc.sv
// Scoreboard bench: three configurations share one stimulus stream and are
// checked against a behavioural model, plus directed checks at key points.
module tb_stack_warning_mc;

    localparam int ND = 3;
    localparam int NC = 2;
    localparam int GRP = 2;
    localparam int C_SLEEP = 4;
    localparam int C_DECAY = 1;
    localparam int C_MODE [ND] = '{0, 1, 0};
    localparam int C_HYST [ND] = '{0, 2, 0};
    localparam int C_CW   [ND] = '{11, 11, 3};

    typedef struct packed {
        logic [15:0] st;
        logic        wr;
        logic        gd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v, d, c;
    logic [1:0]  w0, w1, w2, g0, g1, g2;
    logic        a0, a1, a2;
    logic [21:0] s0, s1;
    logic [5:0]  s2;

    int n_checks = 0;
    int n_pass   = 0;
    int m_k  [ND][NC];
    int m_aw [ND][NC];
    int m_st [ND][NC];
    int m_wr [ND][NC];
    int m_gd [ND][NC];
    exp_t sb[$];

    always #5 clk = ~clk;

    stack_warning_mc #(.CH(2), .GROUP(GRP), .SLEEPTIME(C_SLEEP), .HYST(0), .MODE(0),
                       .DECAY(C_DECAY), .CNT_W(11)) dut0 (
        .clk(clk), .rst(rst), .valid_in(v), .data_in(d), .clr_in(c),
        .warning(w0), .warning_any(a0), .stack_out(s0), .group_done(g0));

    stack_warning_mc #(.CH(2), .GROUP(GRP), .SLEEPTIME(C_SLEEP), .HYST(2), .MODE(1),
                       .DECAY(C_DECAY), .CNT_W(11)) dut1 (
        .clk(clk), .rst(rst), .valid_in(v), .data_in(d), .clr_in(c),
        .warning(w1), .warning_any(a1), .stack_out(s1), .group_done(g1));

    stack_warning_mc #(.CH(2), .GROUP(GRP), .SLEEPTIME(C_SLEEP), .HYST(0), .MODE(0),
                       .DECAY(C_DECAY), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .valid_in(v), .data_in(d), .clr_in(c),
        .warning(w2), .warning_any(a2), .stack_out(s2), .group_done(g2));

    function automatic int get_stack(int di, int ci);
        case (di)
            0:       return int'(s0[ci*11 +: 11]);
            1:       return int'(s1[ci*11 +: 11]);
            2:       return int'(s2[ci*3 +: 3]);
            default: return -1;
        endcase
    endfunction

    function automatic int get_warn(int di, int ci);
        case (di)
            0:       return int'(w0[ci]);
            1:       return int'(w1[ci]);
            2:       return int'(w2[ci]);
            default: return -1;
        endcase
    endfunction

    function automatic int get_gd(int di, int ci);
        case (di)
            0:       return int'(g0[ci]);
            1:       return int'(g1[ci]);
            2:       return int'(g2[ci]);
            default: return -1;
        endcase
    endfunction

    function automatic int get_any(int di);
        case (di)
            0:       return int'(a0);
            1:       return int'(a1);
            2:       return int'(a2);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] vv, input logic [1:0] dv,
                              input logic [1:0] cv);
        for (int di = 0; di < ND; di++) begin
            for (int ci = 0; ci < NC; ci++) begin
                if (r || cv[ci]) begin
                    m_k[di][ci] = 0; m_aw[di][ci] = 0; m_st[di][ci] = 0;
                    m_wr[di][ci] = 0; m_gd[di][ci] = 0;
                end else begin
                    m_gd[di][ci] = 0;
                    if (vv[ci]) begin
                        if (m_k[di][ci] == GRP - 1) begin
                            if ((m_aw[di][ci] | int'(dv[ci])) == 0) begin
                                m_st[di][ci] = m_st[di][ci] + 1;
                                if (m_st[di][ci] > (1 << C_CW[di]) - 1)
                                    m_st[di][ci] = (1 << C_CW[di]) - 1;
                            end else if (C_MODE[di] == 0) begin
                                m_st[di][ci] = 0;
                            end else begin
                                m_st[di][ci] = m_st[di][ci] - C_DECAY;
                                if (m_st[di][ci] < 0) m_st[di][ci] = 0;
                            end
                            if (m_st[di][ci] >= C_SLEEP) m_wr[di][ci] = 1;
                            else if (m_st[di][ci] < C_SLEEP - C_HYST[di]) m_wr[di][ci] = 0;
                            m_k[di][ci] = 0; m_aw[di][ci] = 0; m_gd[di][ci] = 1;
                        end else begin
                            m_k[di][ci] = m_k[di][ci] + 1;
                            m_aw[di][ci] = m_aw[di][ci] | int'(dv[ci]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [1:0] vv, input logic [1:0] dv,
                         input logic [1:0] cv);
        exp_t e;
        int   any_exp;
        @(negedge clk);
        rst = r; v = vv; d = dv; c = cv;
        model_step(r, vv, dv, cv);
        for (int di = 0; di < ND; di++) begin
            for (int ci = 0; ci < NC; ci++) begin
                e.st = 16'(m_st[di][ci]);
                e.wr = m_wr[di][ci][0];
                e.gd = m_gd[di][ci][0];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int di = 0; di < ND; di++) begin
            any_exp = 0;
            for (int ci = 0; ci < NC; ci++) begin
                e = sb.pop_front();
                check($sformatf("d%0d c%0d stack", di, ci), get_stack(di, ci), int'(e.st));
                check($sformatf("d%0d c%0d warning", di, ci), get_warn(di, ci), int'(e.wr));
                check($sformatf("d%0d c%0d group_done", di, ci), get_gd(di, ci), int'(e.gd));
                any_exp = any_exp | int'(e.wr);
            end
            check($sformatf("d%0d warning_any", di), get_any(di), any_exp);
        end
    endtask

    initial begin
        rst = 1'b1; v = 2'b00; d = 2'b00; c = 2'b00;

        for (int i = 0; i < 4; i++) cycle(1'b1, 2'($urandom), 2'($urandom), 2'b00);
        check("reset stack_out d0", int'(s0), 0);
        check("reset warning_any d0", int'(a0), 0);
        check("reset group_done d0", int'(g0), 0);

        cycle(1'b0, 2'b01, 2'b00, 2'b00);
        cycle(1'b0, 2'b00, 2'b00, 2'b00);
        cycle(1'b0, 2'b00, 2'b00, 2'b00);
        check("partial window stack", get_stack(0, 0), 0);
        check("partial window gd", get_gd(0, 0), 0);

        cycle(1'b1, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b01, 2'b00, 2'b00);
        check("8 asleep stack ch0", get_stack(0, 0), 4);
        check("8 asleep warning ch0", get_warn(0, 0), 1);
        check("8 asleep warning_any", get_any(0), 1);
        check("8 asleep stack ch1", get_stack(0, 1), 0);

        cycle(1'b0, 2'b01, 2'b01, 2'b00);
        cycle(1'b0, 2'b01, 2'b00, 2'b00);
        check("awake window stack m0", get_stack(0, 0), 0);
        check("awake window warning m0", get_warn(0, 0), 0);
        check("leaky stack 3", get_stack(1, 0), 3);
        check("leaky warn at 3", get_warn(1, 0), 1);
        cycle(1'b0, 2'b01, 2'b01, 2'b00);
        cycle(1'b0, 2'b01, 2'b01, 2'b00);
        check("leaky stack 2", get_stack(1, 0), 2);
        check("leaky warn at 2", get_warn(1, 0), 1);
        cycle(1'b0, 2'b01, 2'b01, 2'b00);
        cycle(1'b0, 2'b01, 2'b01, 2'b00);
        check("leaky stack 1", get_stack(1, 0), 1);
        check("leaky warn at 1", get_warn(1, 0), 0);

        for (int i = 0; i < 40; i++) cycle(1'b0, 2'b11, 2'b00, 2'b00);
        check("saturate ch0", get_stack(2, 0), 7);
        check("saturate ch1", get_stack(2, 1), 7);
        check("wide count ch0", get_stack(0, 0), 20);

        cycle(1'b0, 2'b11, 2'b00, 2'b00);
        cycle(1'b0, 2'b11, 2'b00, 2'b01);
        check("clr stack ch0", get_stack(0, 0), 0);
        check("clr warning ch0", get_warn(0, 0), 0);
        check("clr neighbour ch1", get_stack(0, 1), 21);
        cycle(1'b0, 2'b11, 2'b00, 2'b00);
        cycle(1'b0, 2'b11, 2'b00, 2'b00);
        check("after clr stack ch0", get_stack(0, 0), 1);
        check("after clr stack ch1", get_stack(0, 1), 22);

        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [1:0] dv, cv;
            r = ($urandom_range(0, 59) == 0);
            for (int b = 0; b < 2; b++) begin
                dv[b] = ($urandom_range(0, 3) == 0);
                cv[b] = ($urandom_range(0, 31) == 0);
            end
            cycle(r, 2'($urandom), dv, cv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
